flash_read: RTL and testbench



---
 rtl/flash_pkg.sv | 21 ++
 rtl/flash_read.sv | 192 +++++++++++++++++++
 tb/tb_flash_read.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// Shared SPI NOR flash definitions: opcodes, address width and the read-controller state encoding.
package flash_pkg;

  localparam int ADDR_W  = 24;
  localparam int MAX_LEN = 256;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_RDSR      = 8'h05;
  localparam logic [7:0] CMD_WREN      = 8'h06;
  localparam logic [7:0] CMD_WRDI      = 8'h04;
  localparam logic [7:0] CMD_PP        = 8'h02;
  localparam logic [7:0] CMD_SE        = 8'h20;
  localparam logic [7:0] CMD_DUMMY     = 8'h00;

  typedef enum logic [3:0] {
    IDLE, CHK, SR_CMD, SR_DAT, SR_END, GAP,
    RD_CMD, RD_ADDR, RD_DUMMY, RD_DATA, RD_END, RPT
  } rd_state_e;

endpackage

// File: rtl/flash_read.sv
// SPI NOR read controller: polls RDSR until WIP clears, then streams READ data over the spi_master byte port.
// Define FLASH_RD_FAST_EN to use FAST_READ (0x0B) with one dummy byte after the address.
module flash_read
  import flash_pkg::*;
#(
  parameter int          LEN_W    = 9,
  parameter logic [15:0] POLL_MAX = 16'd1000,
  parameter int          CS_GAP   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rden,
  input  logic [ADDR_W-1:0] rdaddr,
  input  logic [LEN_W-1:0]  rdlen,
  output logic [7:0]        rd_data,
  output logic              rd_vld,
  output logic              rddone,
  output logic              busy,
  output logic [1:0]        fail,
  input  logic              done,
  input  logic [7:0]        dout,
  output logic              req,
  output logic [7:0]        din,
  output logic              finish
);

`ifdef FLASH_RD_FAST_EN
  localparam logic [7:0] RD_OPCODE = CMD_FAST_READ;
  localparam bit         FAST_EN   = 1'b1;
`else
  localparam logic [7:0] RD_OPCODE = CMD_READ;
  localparam bit         FAST_EN   = 1'b0;
`endif

  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  rd_state_e         r_state;
  rd_state_e         w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_rem;
  logic [1:0]        r_idx;
  logic [15:0]       r_polls;
  logic [GAP_W-1:0]  r_gap;
  logic              r_wip;
  logic              r_sent;
  logic [7:0]        r_rd_data;
  logic              r_rd_vld;
  logic [1:0]        r_fail;
  logic [1:0]        w_fail_nxt;
  logic              w_byte_st;
  logic [7:0]        w_tx_byte;
  logic              w_byte_done;
  logic              w_len_bad;
  logic              w_gap_end;

  // r_sent marks a byte in flight; done is only honoured while it is set.
  assign w_byte_done = r_sent & done;
  assign w_len_bad   = (r_rem == '0) || (r_rem > LEN_W'(MAX_LEN));
  assign w_gap_end   = (r_gap == GAP_W'(CS_GAP - 1));

  assign rd_data = r_rd_data;
  assign rd_vld  = r_rd_vld;
  assign fail    = r_fail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_fail_nxt = 2'b00;
    unique case (r_state)
      IDLE:     if (rden) w_next = CHK;
      CHK: begin
        if (w_len_bad) begin
          w_next        = IDLE;
          w_fail_nxt[1] = 1'b1;
        end else begin
          w_next = SR_CMD;
        end
      end
      SR_CMD:   if (w_byte_done) w_next = SR_DAT;
      SR_DAT:   if (w_byte_done) w_next = SR_END;
      SR_END:   w_next = GAP;
      GAP: begin
        if (w_gap_end) begin
          if (!r_wip) begin
            w_next = RD_CMD;
          end else if (r_polls == POLL_MAX) begin
            w_next        = IDLE;
            w_fail_nxt[0] = 1'b1;
          end else begin
            w_next = SR_CMD;
          end
        end
      end
      RD_CMD:   if (w_byte_done) w_next = RD_ADDR;
      RD_ADDR:  if (w_byte_done && r_idx == 2'd2) w_next = FAST_EN ? RD_DUMMY : RD_DATA;
      RD_DUMMY: if (w_byte_done) w_next = RD_DATA;
      RD_DATA:  if (w_byte_done && r_rem == LEN_W'(1)) w_next = RD_END;
      RD_END:   w_next = RPT;
      RPT:      w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_byte_st = 1'b0;
    w_tx_byte = CMD_DUMMY;
    finish    = 1'b0;
    rddone    = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      IDLE:                      busy = 1'b0;
      SR_CMD: begin
        w_byte_st = 1'b1;
        w_tx_byte = CMD_RDSR;
      end
      SR_DAT, RD_DUMMY, RD_DATA: w_byte_st = 1'b1;
      SR_END, RD_END:            finish = 1'b1;
      RD_CMD: begin
        w_byte_st = 1'b1;
        w_tx_byte = RD_OPCODE;
      end
      RD_ADDR: begin
        w_byte_st = 1'b1;
        unique case (r_idx)
          2'd0:    w_tx_byte = r_addr[23:16];
          2'd1:    w_tx_byte = r_addr[15:8];
          default: w_tx_byte = r_addr[7:0];
        endcase
      end
      RPT: begin
        busy   = 1'b0;
        rddone = 1'b1;
      end
      default: ;
    endcase
    req = w_byte_st & ~r_sent;
    din = req ? w_tx_byte : 8'h00;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_rem     <= '0;
      r_idx     <= '0;
      r_polls   <= '0;
      r_gap     <= '0;
      r_wip     <= 1'b0;
      r_sent    <= 1'b0;
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
      r_fail    <= '0;
    end else begin
      r_rd_vld <= 1'b0;
      r_fail   <= w_fail_nxt;
      if (req)              r_sent <= 1'b1;
      else if (w_byte_done) r_sent <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (rden) begin
            r_addr  <= rdaddr;
            r_rem   <= rdlen;
            r_polls <= '0;
          end
        end
        SR_DAT:  if (w_byte_done) r_wip <= dout[0];
        SR_END:  r_gap <= '0;
        GAP: begin
          r_gap <= r_gap + 1'b1;
          if (w_gap_end && r_wip) r_polls <= r_polls + 16'd1;
        end
        RD_CMD:  r_idx <= '0;
        RD_ADDR: if (w_byte_done) r_idx <= r_idx + 2'd1;
        RD_DATA: begin
          if (w_byte_done) begin
            r_rd_data <= dout;
            r_rd_vld  <= 1'b1;
            r_rem     <= r_rem - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_read.sv
// Self-checking bench for flash_read: a behavioural SPI flash (status + content model) answers each byte,
// and every request is scored against the MOSI stream, read data and timing the controller should produce.
module tb_flash_read;

  localparam int          LEN_W    = 9;
  localparam logic [15:0] POLL_MAX = 16'd5;
  localparam int          CS_GAP   = 4;
`ifdef FLASH_RD_FAST_EN
  localparam bit         FAST = 1'b1;
  localparam logic [7:0] OPC  = 8'h0B;
`else
  localparam bit         FAST = 1'b0;
  localparam logic [7:0] OPC  = 8'h03;
`endif

  logic             clk;
  logic             rst;
  logic             rden;
  logic [23:0]      rdaddr;
  logic [LEN_W-1:0] rdlen;
  logic [7:0]       rd_data;
  logic             rd_vld;
  logic             rddone;
  logic             busy;
  logic [1:0]       fail;
  logic             done;
  logic [7:0]       dout;
  logic             req;
  logic [7:0]       din;
  logic             finish;

  flash_read #(.LEN_W(LEN_W), .POLL_MAX(POLL_MAX), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst(rst), .rden(rden), .rdaddr(rdaddr), .rdlen(rdlen),
    .rd_data(rd_data), .rd_vld(rd_vld), .rddone(rddone), .busy(busy), .fail(fail),
    .done(done), .dout(dout), .req(req), .din(din), .finish(finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Flash array content: a fixed scramble of the byte address.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    logic [7:0] mix;
    mix = a[15:8] * 8'd7;
    return (a[7:0] + mix) ^ a[23:16] ^ 8'hC3;
  endfunction

  // Observation state, cleared at the start of every request.
  int         mosi_q[$];
  logic [7:0] rx_q[$];
  int         vld_q[$];
  int         dd_q[$];
  int         gap_q[$];
  int         n_rddone, n_fail0, n_fail1;
  int         fail_cyc, done_cyc, busy_at_done, busy_post_fail;
  int         first_req_cyc, last_fin_cyc, extra_req;
  int         wip_left;
  logic [23:0] cur_addr;
  int         cur_len, cur_polls, start_cyc;

  // SPI slave: one byte per req, done after 1..4 cycles, decodes RDSR and READ transactions.
  initial begin : slave
    int         idx;
    int         lat;
    int         first_data;
    bit         is_data;
    logic [7:0] op;
    logic [7:0] b;
    logic [7:0] rsp;
    logic [23:0] a;
    done = 1'b0;
    dout = 8'h00;
    idx  = 0;
    op   = 8'h00;
    a    = 24'h0;
    first_data = FAST ? 5 : 4;
    @(posedge clk); #1;
    forever begin
      if (rst) begin
        idx = 0;
        @(posedge clk); #1;
      end else if (finish) begin
        mosi_q.push_back(-1);
        last_fin_cyc = cyc;
        idx = 0;
        @(posedge clk); #1;
      end else if (req) begin
        b = din;
        mosi_q.push_back(int'(b));
        if (idx == 0) begin
          op = b;
          if (first_req_cyc < 0) first_req_cyc = cyc;
          if (last_fin_cyc >= 0) gap_q.push_back(cyc - last_fin_cyc - 1);
        end
        rsp = 8'($urandom());
        is_data = 1'b0;
        if (op == 8'h05 && idx == 1) begin
          rsp[0] = (wip_left > 0);
          if (wip_left > 0) wip_left--;
        end else if (op == OPC && idx >= 1 && idx <= 3) begin
          a = {a[15:0], b};
        end else if (op == OPC && idx >= first_data) begin
          rsp = mem_byte(a + 24'(idx - first_data));
          is_data = 1'b1;
        end
        idx++;
        lat = $urandom_range(3, 0);
        repeat (1 + lat) begin
          @(posedge clk); #1;
          if (req) extra_req++;
        end
        if (is_data) dd_q.push_back(cyc);
        done = 1'b1;
        dout = rsp;
        @(posedge clk); #1;
        done = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  always @(negedge clk) begin
    if (rd_vld) begin
      rx_q.push_back(rd_data);
      vld_q.push_back(cyc);
    end
    if (rddone) begin
      n_rddone++;
      done_cyc     = cyc;
      busy_at_done = int'(busy);
    end
    if (fail[0]) begin
      n_fail0++;
      fail_cyc = cyc;
    end
    if (fail[1]) begin
      n_fail1++;
      fail_cyc = cyc;
    end
    if (fail_cyc >= 0 && cyc == fail_cyc + 1) busy_post_fail = int'(busy);
  end

  task automatic start_req(input logic [23:0] addr, input int len, input int polls);
    mosi_q.delete(); rx_q.delete(); vld_q.delete(); dd_q.delete(); gap_q.delete();
    n_rddone = 0; n_fail0 = 0; n_fail1 = 0;
    fail_cyc = -1; done_cyc = -1; busy_at_done = 2; busy_post_fail = 2;
    first_req_cyc = -1; last_fin_cyc = -1; extra_req = 0;
    wip_left  = polls;
    cur_addr  = addr;
    cur_len   = len;
    cur_polls = polls;
    start_cyc = cyc;
    rden   = 1'b1;
    rdaddr = addr;
    rdlen  = LEN_W'(len);
    @(posedge clk); #1;
    rden = 1'b0;
    check("busy_after_rden", busy, 1);
  endtask

  task automatic wait_end();
    for (int i = 0; i < 4000; i++) begin
      if (n_rddone + n_fail0 + n_fail1 > 0) break;
      @(posedge clk); #1;
    end
    check("end_within_budget", (n_rddone + n_fail0 + n_fail1 > 0), 1);
    repeat (8) begin @(posedge clk); #1; end
  endtask

  task automatic check_req();
    int exp_q[$];
    int npoll;
    int n;
    bit legal;
    bit tmo;
    legal = (cur_len >= 1) && (cur_len <= 256);
    tmo   = cur_polls > int'(POLL_MAX);
    if (!legal) begin
      check("len_fail1", n_fail1, 1);
      check("len_fail1_cycle", fail_cyc - start_cyc, 2);
      check("len_no_req", mosi_q.size(), 0);
      check("len_no_rddone", n_rddone + n_fail0, 0);
      return;
    end
    npoll = tmo ? int'(POLL_MAX) + 1 : cur_polls + 1;
    for (int p = 0; p < npoll; p++) begin
      exp_q.push_back(8'h05);
      exp_q.push_back(8'h00);
      exp_q.push_back(-1);
    end
    if (!tmo) begin
      exp_q.push_back(int'(OPC));
      exp_q.push_back(int'(cur_addr[23:16]));
      exp_q.push_back(int'(cur_addr[15:8]));
      exp_q.push_back(int'(cur_addr[7:0]));
      if (FAST) exp_q.push_back(8'h00);
      for (int k = 0; k < cur_len; k++) exp_q.push_back(8'h00);
      exp_q.push_back(-1);
    end
    check("mosi_count", mosi_q.size(), exp_q.size());
    n = (mosi_q.size() < exp_q.size()) ? mosi_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("mosi[%0d]", i), mosi_q[i], exp_q[i]);
    check("first_req_cycle", first_req_cyc - start_cyc, 2);
    check("no_req_before_done", extra_req, 0);
    check("gap_count", gap_q.size(), tmo ? npoll - 1 : npoll);
    foreach (gap_q[i]) check($sformatf("cs_gap[%0d]_ok", i), (gap_q[i] >= CS_GAP), 1);
    if (tmo) begin
      check("wip_fail0", n_fail0, 1);
      check("wip_no_rddone", n_rddone + n_fail1, 0);
      check("wip_busy_after_fail", busy_post_fail, 0);
    end else begin
      check("rddone_count", n_rddone, 1);
      check("no_fail", n_fail0 + n_fail1, 0);
      check("busy_at_rddone", busy_at_done, 0);
      check("rd_vld_count", rx_q.size(), cur_len);
      n = (rx_q.size() < cur_len) ? rx_q.size() : cur_len;
      for (int i = 0; i < n; i++)
        check($sformatf("rd_data[%0d]", i), rx_q[i], mem_byte(cur_addr + 24'(i)));
      n = (vld_q.size() < dd_q.size()) ? vld_q.size() : dd_q.size();
      for (int i = 0; i < n; i++) check($sformatf("rd_vld_lat[%0d]", i), vld_q[i] - dd_q[i], 1);
      if (vld_q.size() > 0) check("rddone_after_last", done_cyc - vld_q[vld_q.size()-1], 1);
    end
  endtask

  task automatic run_req(input logic [23:0] addr, input int len, input int polls);
    start_req(addr, len, polls);
    wait_end();
    check_req();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    rden   = 1'b0;
    rdaddr = 24'h0;
    rdlen  = '0;
    wip_left = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {rd_data, rd_vld, rddone, busy, fail, req, din, finish}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_outputs", {rd_data, rd_vld, rddone, busy, fail, req, din, finish}, 0);

    run_req(24'h012345, 4, 0);
    run_req(24'h0A0B0C, 8, 3);
    run_req(24'h100000, 4, 100);
    run_req(24'h000010, 0, 0);
    run_req(24'h000020, 257, 0);
    run_req(24'hFFFFFE, 6, 0);
    run_req(24'h222222, 2, 0);
    run_req(24'h000007, 1, 0);
    run_req(24'hABCDEF, 256, 1);

    // Extra rden during the data phase must be ignored.
    start_req(24'h345678, 40, 1);
    for (int i = 0; i < 2000 && rx_q.size() < 3; i++) begin @(posedge clk); #1; end
    rden   = 1'b1;
    rdaddr = 24'h999999;
    rdlen  = LEN_W'(5);
    @(posedge clk); #1;
    rden = 1'b0;
    wait_end();
    check_req();

    // Reset in the middle of RD_DATA, then a fresh request.
    start_req(24'h00F000, 64, 0);
    for (int i = 0; i < 2000 && rx_q.size() < 5; i++) begin @(posedge clk); #1; end
    check("reached_rd_data", (rx_q.size() >= 5), 1);
    rst = 1'b1;
    @(negedge clk);
    check("outputs_in_reset", {rd_data, rd_vld, rddone, busy, fail, req, din, finish}, 0);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("outputs_after_reset", {rd_data, rd_vld, rddone, busy, fail, req, din, finish}, 0);
    run_req(24'h0F0F0F, 5, 2);

    for (int t = 0; t < 14; t++) begin
      int          sel;
      int          len;
      int          polls;
      logic [23:0] a;
      sel   = $urandom_range(9, 0);
      a     = 24'($urandom());
      len   = $urandom_range(40, 1);
      polls = $urandom_range(3, 0);
      if (sel == 0) len = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(511, 257);
      if (sel == 1) polls = int'(POLL_MAX) + 1 + $urandom_range(3, 0);
      if (sel == 2) a = 24'hFFFFF0 + 24'($urandom_range(15, 0));
      run_req(a, len, polls);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
